// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared types, response codes and helpers for the AXI-Lite register slave
package axil_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] RO_ID_VALUE = 32'h484F_4C59;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_t;

    typedef struct packed {
        logic       hit;
        logic       is_id;
        logic [5:0] idx;
    } dec_t;

    function automatic logic [31:0] merge_wstrb(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int j = 0; j < 4; j++) begin
            if (strb[j]) res[8*j +: 8] = new_val[8*j +: 8];
        end
        return res;
    endfunction

    // is_id flags the word just past the register bank; the caller decides whether it exists
    function automatic dec_t decode_addr(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] n_regs
    );
        dec_t        d;
        logic [31:0] word;
        word    = (addr - base) >> 2;
        d.idx   = 6'(word);
        d.hit   = (addr >= base) && (word < n_regs);
        d.is_id = (addr >= base) && (word == n_regs);
        return d;
    endfunction

endpackage

// File: rtl/axil_reg_slave.sv
// rtl/axil_reg_slave.sv - AXI-Lite register bank responder; optional read-only ID word via AXIL_REG_SLAVE_RO_ID_EN
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int          N_REGS    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          s_axi_lite_awaddr,
    input  logic                 s_axi_lite_awvalid,
    output logic                 s_axi_lite_awready,
    input  logic [31:0]          s_axi_lite_wdata,
    input  logic [3:0]           s_axi_lite_wstrb,
    input  logic                 s_axi_lite_wvalid,
    output logic                 s_axi_lite_wready,
    output logic [1:0]           s_axi_lite_bresp,
    output logic                 s_axi_lite_bvalid,
    input  logic                 s_axi_lite_bready,
    input  logic [31:0]          s_axi_lite_araddr,
    input  logic                 s_axi_lite_arvalid,
    output logic                 s_axi_lite_arready,
    output logic [31:0]          s_axi_lite_rdata,
    output logic [1:0]           s_axi_lite_rresp,
    output logic                 s_axi_lite_rvalid,
    input  logic                 s_axi_lite_rready,
    output logic [N_REGS*32-1:0] reg_out,
    output logic [N_REGS-1:0]    reg_wr_pulse
);

    logic [31:0] regs [N_REGS];

    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;
    logic        aw_hs, w_hs, ar_hs, commit;
    logic [31:0] aw_addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] w_addr_eff, w_data_eff;
    logic [3:0]  w_strb_eff;
    dec_t        w_dec, r_dec;
    logic [31:0] rdata_n;
    logic [1:0]  rresp_n;

    // Write FSM: readies, handshakes and next state
    always_comb begin
        w_next             = w_state;
        s_axi_lite_awready = 1'b0;
        s_axi_lite_wready  = 1'b0;
        if (!rst) begin
            case (w_state)
                W_IDLE:    begin s_axi_lite_awready = 1'b1; s_axi_lite_wready = 1'b1; end
                W_HAVE_AW: s_axi_lite_wready  = 1'b1;
                W_HAVE_W:  s_axi_lite_awready = 1'b1;
                default:   ;
            endcase
        end
        aw_hs = s_axi_lite_awvalid && s_axi_lite_awready;
        w_hs  = s_axi_lite_wvalid && s_axi_lite_wready;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_next = W_RESP;
                else if (aw_hs)    w_next = W_HAVE_AW;
                else if (w_hs)     w_next = W_HAVE_W;
            end
            W_HAVE_AW: if (w_hs)              w_next = W_RESP;
            W_HAVE_W:  if (aw_hs)             w_next = W_RESP;
            W_RESP:    if (s_axi_lite_bready) w_next = W_IDLE;
            default:   w_next = W_IDLE;
        endcase
        commit = (w_state != W_RESP) && (w_next == W_RESP);
    end

    // The channel arriving on the commit edge bypasses its holding register
    assign w_addr_eff = aw_hs ? s_axi_lite_awaddr : aw_addr_q;
    assign w_data_eff = w_hs  ? s_axi_lite_wdata  : wdata_q;
    assign w_strb_eff = w_hs  ? s_axi_lite_wstrb  : wstrb_q;
    assign w_dec      = decode_addr(w_addr_eff, BASE_ADDR, 32'(N_REGS));

    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_REGS; k++) regs[k] <= '0;
            reg_wr_pulse     <= '0;
            s_axi_lite_bresp <= RESP_OKAY;
            aw_addr_q        <= '0;
            wdata_q          <= '0;
            wstrb_q          <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (aw_hs) aw_addr_q <= s_axi_lite_awaddr;
            if (w_hs) begin
                wdata_q <= s_axi_lite_wdata;
                wstrb_q <= s_axi_lite_wstrb;
            end
            if (commit) begin
                s_axi_lite_bresp <= w_dec.hit ? RESP_OKAY : RESP_SLVERR;
                for (int k = 0; k < N_REGS; k++) begin
                    if (w_dec.hit && w_dec.idx == 6'(k)) begin
                        regs[k]         <= merge_wstrb(regs[k], w_data_eff, w_strb_eff);
                        reg_wr_pulse[k] <= 1'b1;
                    end
                end
            end
        end
    end

    assign s_axi_lite_bvalid = (w_state == W_RESP);

    // Read path
    assign s_axi_lite_arready = !rst && (r_state == R_IDLE);
    assign ar_hs              = s_axi_lite_arvalid && s_axi_lite_arready;
    assign r_dec              = decode_addr(s_axi_lite_araddr, BASE_ADDR, 32'(N_REGS));

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)             r_next = R_RESP;
            R_RESP:  if (s_axi_lite_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        rdata_n = '0;
        rresp_n = r_dec.hit ? RESP_OKAY : RESP_SLVERR;
        for (int k = 0; k < N_REGS; k++) begin
            if (r_dec.hit && r_dec.idx == 6'(k)) rdata_n = regs[k];
        end
`ifdef AXIL_REG_SLAVE_RO_ID_EN
        if (r_dec.is_id) begin
            rdata_n = RO_ID_VALUE;
            rresp_n = RESP_OKAY;
        end
`endif
    end

`ifdef AXIL_REG_SLAVE_RO_ID_EN
    logic unused_id;
    assign unused_id = w_dec.is_id;
`else
    logic unused_id;
    assign unused_id = w_dec.is_id ^ r_dec.is_id;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    // Sampled from the pre-edge register values, so a same-cycle write is not visible
    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_lite_rdata <= '0;
            s_axi_lite_rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axi_lite_rdata <= rdata_n;
            s_axi_lite_rresp <= rresp_n;
        end
    end

    assign s_axi_lite_rvalid = (r_state == R_RESP);

    for (genvar k = 0; k < N_REGS; k++) begin : g_out
        assign reg_out[32*k +: 32] = regs[k];
    end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI-Lite responder, i.e. the target at the other end of the core's AXI-Lite master port.
- Provides a bank of N_REGS 32-bit read/write registers for SoC-side control and status peripherals.
- Handles AW/W in either order and honours byte strobes.
- Returns OKAY or SLVERR responses.
- Exposes register contents and a per-write pulse to the surrounding fabric.

Parameters:
- N_REGS, 8, number of 32-bit registers (2..64).
- BASE_ADDR, 32'h0000_3000, byte address of register 0 (word aligned).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- s_axi_lite_awaddr  in  32  write address
- s_axi_lite_awvalid  in  1  write address valid
- s_axi_lite_awready  out  1  write address accepted
- s_axi_lite_wdata  in  32  write data
- s_axi_lite_wstrb  in  4  byte enables
- s_axi_lite_wvalid  in  1  write data valid
- s_axi_lite_wready  out  1  write data accepted
- s_axi_lite_bresp  out  2  write response (00 OKAY, 10 SLVERR)
- s_axi_lite_bvalid  out  1  write response valid
- s_axi_lite_bready  in  1  write response taken
- s_axi_lite_araddr  in  32  read address
- s_axi_lite_arvalid  in  1  read address valid
- s_axi_lite_arready  out  1  read address accepted
- s_axi_lite_rdata  out  32  read data
- s_axi_lite_rresp  out  2  read response
- s_axi_lite_rvalid  out  1  read data valid
- s_axi_lite_rready  in  1  read data taken
- reg_out  out  N_REGS*32  flattened register contents, reg k at bits [32k+31:32k]
- reg_wr_pulse  out  N_REGS  one-cycle pulse on the cycle register k commits a write

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all registers, bvalid, rvalid, bresp, rresp, rdata, reg_wr_pulse are 0. All readies are 0 while rst is high.
- Decode: word index = (addr - BASE_ADDR) >> 2. Hit when the subtraction does not underflow and index < N_REGS. addr[1:0] is ignored.
- Write path, FSM W_IDLE / W_HAVE_AW / W_HAVE_W / W_RESP:
  - awready = 1 in W_IDLE and W_HAVE_W.
  - wready = 1 in W_IDLE and W_HAVE_AW.
  - Each handshake captures its channel (addr, or data+strb) into holding registers.
  - Both captured in the same cycle, or the second one arrives: move to W_RESP on the next edge.
  - On that same edge: commit the write on hit, set bvalid=1 and bresp, pulse reg_wr_pulse[index] for one cycle.
  - Commit updates byte j only where wstrb[j]=1.
  - Miss: no register changes, no pulse, bresp=SLVERR.
  - bvalid holds with stable bresp until bready. W_RESP with bready returns to W_IDLE; both readies are 0 during W_RESP.
  - Latency: AW+W accepted together -> bvalid asserted the next cycle. One outstanding write maximum.
- Read path, FSM R_IDLE / R_RESP:
  - arready = 1 only in R_IDLE.
  - On handshake, rdata and rresp are registered on the same edge and rvalid=1 the next cycle (1-cycle latency).
  - Miss: rdata=0, rresp=SLVERR.
  - rvalid, rdata and rresp stay stable until rready, then return to R_IDLE. arready is 0 while rvalid=1.
- Read and write paths are independent and may run concurrently.
- Read and write commit to the same register in the same cycle: the read returns the pre-write value.
- wstrb=0000: legal; OKAY, no data change, reg_wr_pulse still fires.
- rst asserted mid-transaction: both FSMs return to idle, pending responses are dropped, registers clear.
- Master must re-issue after reset.

Optional Feature:
- Macro AXIL_REG_SLAVE_RO_ID_EN.
- Defined:
  - Word index N_REGS is an extra read-only ID register returning 32'h484F_4C59.
  - Reads of it give OKAY.
  - Writes to it give SLVERR, change nothing and produce no pulse.
- Undefined: index N_REGS is a miss like any other out-of-range address.

Decomposition:
- Package axil_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - write FSM enum and read FSM enum
  - ID constant 32'h484F_4C59
- No sub-module. Byte-strobe merge is a function in the package (merge_wstrb(old, new, strb)). Both FSMs stay in one module.

Test Plan:
- AW and W valid together, addr=BASE+4, data=DEADBEEF, strb=F -> bvalid next cycle, bresp=00, reg_wr_pulse[1] for one cycle, reg_out[63:32]=DEADBEEF.
- W two cycles before AW, addr=BASE+8, data=12345678, strb=0101 on reg 2 holding AAAAAAAA -> reg 2 becomes AA34AA78, bresp=00, after AW accept.
- bready held low 5 cycles -> bvalid and bresp stable throughout, awready and wready stay 0, second AW is not accepted until the B handshake.
- Read BASE+4 with rready low 3 cycles -> rvalid one cycle after AR, rdata=DEADBEEF stable, arready=0 until rready.
- Read addr=BASE+4*N_REGS and addr=BASE-4 -> rresp=10, rdata=0. Write to the same -> bresp=10, no register change, no pulse. With macro: read of BASE+4*N_REGS -> OKAY, 484F4C59.
- Write to reg 0 with rst pulsed for one cycle after AW accept but before W -> all outputs 0. A subsequent full write completes normally.
